seg7_readback_decoder: RTL and testbench

//  Receive-side counterpart of the seven-segment driver: samples the 7 segment lines a display top

---
 rtl/seg7_readback_decoder.sv | 157 +++++++++++++++
 tb/tb_seg7_readback_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback_decoder.sv
// Seven-segment readback decoder: samples the segment lines, debounces them over
// STABLE_CYCLES matching samples, and decodes the committed pattern back to a hex nibble.
module seg7_readback_decoder #(
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             seg_A_i,
    input  logic             seg_B_i,
    input  logic             seg_C_i,
    input  logic             seg_D_i,
    input  logic             seg_E_i,
    input  logic             seg_F_i,
    input  logic             seg_G_i,
    output logic [3:0]       digit_o,
    output logic             valid_o,
    output logic             blank_o,
    output logic             invalid_o,
    output logic             update_o,
    output logic [CNT_W-1:0] change_cnt_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    // Returns {legal, digit} for a lit-segment pattern ordered {A..G}.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h7B:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h4F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    logic [6:0]    raw;
    logic [6:0]    seg_q;
    logic [6:0]    cand_q;
    logic [6:0]    locked_q;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic          committed_q;
    logic          commit;
    logic [4:0]    dec;

    assign raw = {seg_A_i, seg_B_i, seg_C_i, seg_D_i, seg_E_i, seg_F_i, seg_G_i};

    always_comb begin
        commit = (state == SETTLE) && (seg_q == cand_q) && (cnt == CNT_LAST);
        dec    = decode(cand_q);
    end

    // Sample stage: normalise so that 1 means segment lit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_q <= 7'h00;
        end else begin
            seg_q <= (ACTIVE_LOW != 0) ? ~raw : raw;
        end
    end

    // Debounce stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            cand_q <= 7'h00;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cand_q <= seg_q;
                    cnt    <= CNT_ONE;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (seg_q != cand_q) begin
                        cand_q <= seg_q;
                        cnt    <= CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= CNT_FULL;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (seg_q != cand_q) begin
                        cand_q <= seg_q;
                        cnt    <= CNT_ONE;
                        state  <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit stage: outputs move only when a pattern has been stable long enough.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            locked_q     <= 7'h00;
            committed_q  <= 1'b0;
            digit_o      <= 4'h0;
            valid_o      <= 1'b0;
            blank_o      <= 1'b1;
            invalid_o    <= 1'b0;
            update_o     <= 1'b0;
            change_cnt_o <= '0;
        end else begin
            update_o <= 1'b0;
            if (commit) begin
                locked_q    <= cand_q;
                committed_q <= 1'b1;
                if (!committed_q || (cand_q != locked_q)) begin
                    update_o     <= 1'b1;
                    change_cnt_o <= change_cnt_o + 1'b1;
                end
                if (cand_q == 7'h00) begin
                    valid_o   <= 1'b0;
                    blank_o   <= 1'b1;
                    invalid_o <= 1'b0;
                end else if (dec[4]) begin
                    digit_o   <= dec[3:0];
                    valid_o   <= 1'b1;
                    blank_o   <= 1'b0;
                    invalid_o <= 1'b0;
                end else begin
                    valid_o   <= 1'b0;
                    blank_o   <= 1'b0;
                    invalid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Scoreboard bench for seg7_readback_decoder: stimulus pushes expected commits,
// monitors pop and compare on every update_o pulse of the default and CNT_W=2 instances.
module tb_seg7_readback_decoder;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_BLANK = 2'd1;
    localparam logic [1:0] K_INV   = 2'd2;

    typedef struct packed {
        logic [3:0]  digit;
        logic [1:0]  kind;
        logic [7:0]  cnt;
        logic [31:0] edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    logic [3:0] digit, digit2;
    logic       valid, blank, invalid, update;
    logic       valid2, blank2, invalid2, update2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic [31:0] cyc;
    exp_t q1[$];
    exp_t q2[$];

    logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    seg7_readback_decoder #(.ACTIVE_LOW(1), .STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .seg_A_i(seg_a), .seg_B_i(seg_b), .seg_C_i(seg_c), .seg_D_i(seg_d),
        .seg_E_i(seg_e), .seg_F_i(seg_f), .seg_G_i(seg_g),
        .digit_o(digit), .valid_o(valid), .blank_o(blank), .invalid_o(invalid),
        .update_o(update), .change_cnt_o(cnt)
    );

    seg7_readback_decoder #(.ACTIVE_LOW(1), .STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .seg_A_i(seg_a), .seg_B_i(seg_b), .seg_C_i(seg_c), .seg_D_i(seg_d),
        .seg_E_i(seg_e), .seg_F_i(seg_f), .seg_G_i(seg_g),
        .digit_o(digit2), .valid_o(valid2), .blank_o(blank2), .invalid_o(invalid2),
        .update_o(update2), .change_cnt_o(cnt2)
    );

    // Edge index since reset release: the first rising edge after release is edge 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] flags(input logic [1:0] kind);
        case (kind)
            K_VALID: flags = 3'b100;
            K_BLANK: flags = 3'b010;
            default: flags = 3'b001;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && update) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update actual=digit %0h cnt %0d required=no update", digit, cnt);
            end else begin
                e = q1.pop_front();
                chk("commit_edge", cyc, e.edge_n);
                chk("digit", 32'(digit), 32'(e.digit));
                chk("flags_vbi", 32'({valid, blank, invalid}), 32'(flags(e.kind)));
                chk("change_cnt", 32'(cnt), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && update2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update_w2 actual=cnt %0d required=no update", cnt2);
            end else begin
                e = q2.pop_front();
                chk("commit_edge_w2", cyc, e.edge_n);
                chk("change_cnt_w2", 32'(cnt2), 32'(e.cnt[1:0]));
            end
        end
    end

    task automatic drive(input logic [6:0] pat);
        {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = ~pat;
    endtask

    task automatic push_exp(input logic [3:0] dg, input logic [1:0] kind, input logic [31:0] edge_n);
        exp_t e;
        exp_cnt++;
        e.digit  = dg;
        e.kind   = kind;
        e.cnt    = 8'(exp_cnt);
        e.edge_n = edge_n;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    // Change the pins just after an edge and hold them for 'hold' samples.
    task automatic apply(input logic [6:0] pat, input int hold, input logic upd,
                         input logic [3:0] dg, input logic [1:0] kind);
        @(negedge clk);
        drive(pat);
        if (upd) push_exp(dg, kind, cyc + 32'd5);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'h0);
        chk({tag, "_flags"}, 32'({valid, blank, invalid}), 32'(3'b010));
        chk({tag, "_update"}, 32'(update), 32'h0);
        chk({tag, "_cnt"}, 32'(cnt), 32'h0);
        chk({tag, "_cnt_w2"}, 32'(cnt2), 32'h0);
    endtask

    initial begin
        // Pins held at digit 1 from reset release.
        drive(7'h30);
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset_initial");
        exp_cnt = 0;
        push_exp(4'h1, K_VALID, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("hold_from_reset_digit", 32'(digit), 32'h1);

        // All sixteen glyphs from a fresh reset.
        rst_n = 1'b0;
        drive(7'h7E);
        @(negedge clk);
        exp_cnt = 0;
        push_exp(4'h0, K_VALID, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        for (int i = 1; i < 16; i++) apply(pats[i], 10, 1'b1, 4'(i), K_VALID);
        chk("sweep_final_cnt", 32'(cnt), 32'd16);
        chk("sweep_final_digit", 32'(digit), 32'hF);

        // Short glitch must not commit.
        apply(7'h7E, 10, 1'b1, 4'h0, K_VALID);
        apply(7'h30, 3, 1'b0, 4'h0, K_VALID);
        apply(7'h7E, 10, 1'b0, 4'h0, K_VALID);
        chk("glitch_digit", 32'(digit), 32'h0);
        chk("glitch_flags", 32'({valid, blank, invalid}), 32'(3'b100));
        chk("glitch_cnt", 32'(cnt), 32'd17);

        // Illegal then blank pattern; digit keeps its last legal value.
        apply(7'h01, 10, 1'b1, 4'h0, K_INV);
        chk("invalid_flags", 32'({valid, blank, invalid}), 32'(3'b001));
        apply(7'h00, 10, 1'b1, 4'h0, K_BLANK);
        chk("blank_flags", 32'({valid, blank, invalid}), 32'(3'b010));
        chk("blank_digit", 32'(digit), 32'h0);

        // Reset asserted mid-settle (cnt=2), then re-commit after release.
        apply(7'h33, 10, 1'b1, 4'h4, K_VALID);
        chk("pre_reset_digit", 32'(digit), 32'h4);
        @(negedge clk);
        drive(7'h5B);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_settle");
        chk("unmatched_before_reset", 32'(q1.size()), 32'd0);
        q1.delete();
        q2.delete();
        exp_cnt = 0;
        push_exp(4'h5, K_VALID, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("scoreboard_drained", 32'(q1.size()), 32'd0);
        chk("scoreboard_drained_w2", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
